input_conditioner: RTL and testbench

- Upstream front end for the Moore sequence FSM (`fsm_moore`): converts an asynchronous, bouncy external input (button/switch) into a clean, clock-synchronous level.
- That level drives the FSM's `input_signal` port.
- Also provides single-cycle rise/fall event pulses and a saturating glitch counter for debug.
- Sits between the board pin and the FSM, in the same clock domain as the FSM.

---
 rtl/input_conditioner.sv | 151 +++++++++++++++
 tb/tb_input_conditioner.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced, synchronized front end with edge pulses and glitch counter
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                raw_in,
    input  logic                enable,
    output logic                clean_level,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic [GLITCH_W-1:0] glitch_count
);

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    // Count value on the cycle that completes a check (the first sample counts as 1).
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    logic                s1;
    logic                s2;
    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nx;
    logic                level_nx;
    logic                rise_nx;
    logic                fall_nx;
    logic [GLITCH_W-1:0] glitch_nx;
    logic                check_done;
    logic                check_abort;

    // Two-flop synchronizer; keeps running while the conditioner is frozen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE_LOW;
            cnt          <= '0;
            clean_level  <= 1'b0;
            rise_pulse   <= 1'b0;
            fall_pulse   <= 1'b0;
            glitch_count <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            clean_level  <= level_nx;
            rise_pulse   <= rise_nx;
            fall_pulse   <= fall_nx;
            glitch_count <= glitch_nx;
        end
    end

    // A check completes when the synchronized input has stayed at the candidate
    // value for the full window; it aborts on the first sample back at the old value.
    always_comb begin
        check_done  = 1'b0;
        check_abort = 1'b0;
        if (state == CHECK_HIGH) begin
            check_done  = s2 && (cnt == CNT_LAST);
            check_abort = !s2;
        end else if (state == CHECK_LOW) begin
            check_done  = !s2 && (cnt == CNT_LAST);
            check_abort = s2;
        end
    end

    // Next-state and counter; everything holds while disabled.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (enable) begin
            case (state)
                IDLE_LOW: begin
                    if (s2) begin
                        state_nx = CHECK_HIGH;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                CHECK_HIGH: begin
                    if (check_done) begin
                        state_nx = IDLE_HIGH;
                        cnt_nx   = '0;
                    end else if (check_abort) begin
                        state_nx = IDLE_LOW;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx   = cnt + CNT_W'(1);
                    end
                end
                IDLE_HIGH: begin
                    if (!s2) begin
                        state_nx = CHECK_LOW;
                        cnt_nx   = CNT_W'(1);
                    end
                end
                CHECK_LOW: begin
                    if (check_done) begin
                        state_nx = IDLE_LOW;
                        cnt_nx   = '0;
                    end else if (check_abort) begin
                        state_nx = IDLE_HIGH;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx   = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE_LOW;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Next values of the registered outputs; pulses default low so they last one cycle.
    always_comb begin
        level_nx  = clean_level;
        rise_nx   = 1'b0;
        fall_nx   = 1'b0;
        glitch_nx = glitch_count;
        if (enable) begin
            if (check_done) begin
                level_nx = (state == CHECK_HIGH);
                rise_nx  = (state == CHECK_HIGH);
                fall_nx  = (state == CHECK_LOW);
            end
            if (check_abort && (glitch_count != GLITCH_MAX)) begin
                glitch_nx = glitch_count + GLITCH_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner
module tb_input_conditioner;

    logic       clk;
    logic       resetn;
    logic       raw_in;
    logic       enable;
    logic       clean_level;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_count;

    logic       raw_b;
    logic       en_b;
    logic       level_b;
    logic       rise_b;
    logic       fall_b;
    logic [1:0] glitch_b;

    int checks;
    int failures;

    localparam logic [63:0] ALL_EN = '1;

    input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .GLITCH_W(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .raw_in       (raw_in),
        .enable       (enable),
        .clean_level  (clean_level),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .glitch_count (glitch_count)
    );

    input_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_W(16), .GLITCH_W(2)) dut_sat (
        .clk          (clk),
        .resetn       (resetn),
        .raw_in       (raw_b),
        .enable       (en_b),
        .clean_level  (level_b),
        .rise_pulse   (rise_b),
        .fall_pulse   (fall_b),
        .glitch_count (glitch_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle i drives raw_pat[i] (while i < raw_len) and en_pat[i] at the falling edge
    // before rising edge i+1, then samples the outputs 1 ns after that rising edge.
    task automatic run(input logic [63:0] raw_pat, input int raw_len, input logic [63:0] en_pat,
                       input int cycles, output int chg_edge, output int trans,
                       output int rises, output int falls, output int both);
        logic prev;
        prev     = clean_level;
        chg_edge = 0;
        trans    = 0;
        rises    = 0;
        falls    = 0;
        both     = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (i < raw_len) raw_in = raw_pat[i];
            enable = en_pat[i];
            @(posedge clk);
            #1;
            if (clean_level !== prev) begin
                trans++;
                if (chg_edge == 0) chg_edge = i + 1;
            end
            prev = clean_level;
            if (rise_pulse === 1'b1) rises++;
            if (fall_pulse === 1'b1) falls++;
            if (rise_pulse === 1'b1 && fall_pulse === 1'b1) both++;
        end
    endtask

    task automatic test_reset;
        int edge_at, rises, falls;
        resetn = 1'b0;
        raw_in = 1'b1;
        enable = 1'b1;
        raw_b  = 1'b0;
        en_b   = 1'b1;
        #12;
        checks++;
        if ({clean_level, rise_pulse, fall_pulse, glitch_count} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got level=%b rise=%b fall=%b glitch=%0d, want all 0",
                     clean_level, rise_pulse, fall_pulse, glitch_count);
        end
        checks++;
        if ({level_b, rise_b, fall_b, glitch_b} !== 5'd0) begin
            failures++;
            $display("FAIL reset_outputs_sat: got level=%b glitch=%0d, want 0", level_b, glitch_b);
        end
        @(negedge clk);
        @(negedge clk);
        resetn  = 1'b1;
        edge_at = 0;
        rises   = 0;
        falls   = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (clean_level === 1'b1 && edge_at == 0) edge_at = i;
            if (rise_pulse === 1'b1) rises++;
            if (fall_pulse === 1'b1) falls++;
        end
        checks++;
        if (edge_at != 6) begin
            failures++;
            $display("FAIL reset_release_latency: level rose at edge %0d, want 6", edge_at);
        end
        checks++;
        if (rises != 1 || falls != 0) begin
            failures++;
            $display("FAIL reset_release_pulses: rise cycles=%0d fall cycles=%0d, want 1 and 0", rises, falls);
        end
        checks++;
        if (glitch_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_release_glitch: got %0d, want 0", glitch_count);
        end
    endtask

    task automatic test_clean_press;
        int e, t, r, f, b;
        run(64'd0, 1, ALL_EN, 10, e, t, r, f, b);
        checks++;
        if (e != 6 || f != 1 || r != 0 || b != 0) begin
            failures++;
            $display("FAIL release_from_reset: edge=%0d fall=%0d rise=%0d, want 6 1 0", e, f, r);
        end
        run(64'd1, 1, ALL_EN, 10, e, t, r, f, b);
        checks++;
        if (e != 6 || r != 1 || f != 0 || t != 1 || clean_level !== 1'b1) begin
            failures++;
            $display("FAIL clean_press: edge=%0d rise=%0d fall=%0d trans=%0d level=%b, want 6 1 0 1 1",
                     e, r, f, t, clean_level);
        end
        run(64'd0, 1, ALL_EN, 10, e, t, r, f, b);
        checks++;
        if (e != 6 || f != 1 || r != 0 || t != 1 || clean_level !== 1'b0) begin
            failures++;
            $display("FAIL clean_release: edge=%0d fall=%0d rise=%0d trans=%0d level=%b, want 6 1 0 1 0",
                     e, f, r, t, clean_level);
        end
        checks++;
        if (glitch_count !== 8'd0) begin
            failures++;
            $display("FAIL clean_press_glitch: got %0d, want 0", glitch_count);
        end
    endtask

    // High 2 cycles, low 1 cycle, three times, then high: three aborted checks,
    // the final check starts at edge 12 and completes at edge 15.
    task automatic test_bounce;
        int e, t, r, f, b;
        logic [7:0] g0;
        g0 = glitch_count;
        run(64'h2DB, 10, ALL_EN, 20, e, t, r, f, b);
        checks++;
        if (t != 1 || e != 15 || clean_level !== 1'b1) begin
            failures++;
            $display("FAIL bounce_level: trans=%0d edge=%0d level=%b, want 1 15 1", t, e, clean_level);
        end
        checks++;
        if (r != 1 || f != 0 || b != 0) begin
            failures++;
            $display("FAIL bounce_pulses: rise=%0d fall=%0d both=%0d, want 1 0 0", r, f, b);
        end
        checks++;
        if (glitch_count !== g0 + 8'd3) begin
            failures++;
            $display("FAIL bounce_glitch: got %0d, want %0d", glitch_count, g0 + 8'd3);
        end
        run(64'd0, 1, ALL_EN, 10, e, t, r, f, b);
        checks++;
        if (e != 6 || f != 1 || clean_level !== 1'b0) begin
            failures++;
            $display("FAIL bounce_return_low: edge=%0d fall=%0d level=%b, want 6 1 0", e, f, clean_level);
        end
    endtask

    // Raw high across two sampling edges only.
    task automatic test_short_glitch;
        int e, t, r, f, b;
        logic [7:0] g0;
        g0 = glitch_count;
        run(64'h3, 3, ALL_EN, 12, e, t, r, f, b);
        checks++;
        if (t != 0 || clean_level !== 1'b0) begin
            failures++;
            $display("FAIL short_glitch_level: trans=%0d level=%b, want 0 0", t, clean_level);
        end
        checks++;
        if (r != 0 || f != 0) begin
            failures++;
            $display("FAIL short_glitch_pulses: rise=%0d fall=%0d, want 0 0", r, f);
        end
        checks++;
        if (glitch_count !== g0 + 8'd1) begin
            failures++;
            $display("FAIL short_glitch_count: got %0d, want %0d", glitch_count, g0 + 8'd1);
        end
    endtask

    // Check starts at edge 3 (cnt=1), edge 4 (cnt=2); edges 5..9 frozen;
    // edge 10 cnt=3, edge 11 completes.
    task automatic test_enable_freeze;
        int e, t, r, f, b;
        logic [63:0] en_pat;
        en_pat = ~64'h1F0;
        run(64'd1, 1, en_pat, 16, e, t, r, f, b);
        checks++;
        if (e != 11 || t != 1) begin
            failures++;
            $display("FAIL freeze_latency: level changed at edge %0d trans=%0d, want 11 1", e, t);
        end
        checks++;
        if (r != 1 || f != 0) begin
            failures++;
            $display("FAIL freeze_pulses: rise=%0d fall=%0d, want 1 0", r, f);
        end
        run(64'd0, 1, ALL_EN, 10, e, t, r, f, b);
        checks++;
        if (e != 6 || f != 1 || clean_level !== 1'b0) begin
            failures++;
            $display("FAIL freeze_return_low: edge=%0d fall=%0d level=%b, want 6 1 0", e, f, clean_level);
        end
    endtask

    // Bounce on both press and release; the downstream FSM must see one 0->1->0.
    task automatic test_system;
        int e, t, r, f, b;
        logic [7:0] g0;
        g0 = glitch_count;
        run(64'hBFD, 13, ALL_EN, 24, e, t, r, f, b);
        checks++;
        if (t != 2 || e != 8 || clean_level !== 1'b0) begin
            failures++;
            $display("FAIL system_sequence: trans=%0d first=%0d level=%b, want 2 8 0", t, e, clean_level);
        end
        checks++;
        if (r != 1 || f != 1 || b != 0) begin
            failures++;
            $display("FAIL system_pulses: rise=%0d fall=%0d both=%0d, want 1 1 0", r, f, b);
        end
        checks++;
        if (glitch_count !== g0 + 8'd2) begin
            failures++;
            $display("FAIL system_glitch: got %0d, want %0d", glitch_count, g0 + 8'd2);
        end
    endtask

    task automatic test_saturation_reset;
        int pulses;
        pulses = 0;
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                raw_b = (i < 2);
                @(posedge clk);
                #1;
                if (rise_b === 1'b1 || fall_b === 1'b1) pulses++;
            end
            if (g == 2) begin
                checks++;
                if (glitch_b !== 2'd3) begin
                    failures++;
                    $display("FAIL sat_reach: got %0d after 3 glitches, want 3", glitch_b);
                end
            end
        end
        checks++;
        if (glitch_b !== 2'd3 || pulses != 0 || level_b !== 1'b0) begin
            failures++;
            $display("FAIL sat_hold: glitch=%0d pulses=%0d level=%b, want 3 0 0", glitch_b, pulses, level_b);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            raw_b = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (level_b !== 1'b1) begin
            failures++;
            $display("FAIL sat_press: level=%b, want 1", level_b);
        end
        @(negedge clk);
        raw_b = 1'b0;
        for (int i = 0; i < 4; i++) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        checks++;
        if (level_b !== 1'b0 || glitch_b !== 2'd0 || fall_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_check: level=%b glitch=%0d fall=%b, want 0 0 0", level_b, glitch_b, fall_b);
        end
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (fall_b === 1'b1 || rise_b === 1'b1 || level_b !== 1'b0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_mid_check_after: %0d cycles with pulse or level set, want 0", pulses);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_clean_press;
        test_bounce;
        test_short_glitch;
        test_enable_freeze;
        test_system;
        test_saturation_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
